// File: rtl/io_ctrl_if.sv
// Data-memory port bundle between the memory stage (master) and the
// memory-mapped I/O controller (slave).
interface io_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] ADDR;
  logic [DBITS-1:0] DIN;
  logic             WE;
  logic             SEL;
  logic [DBITS-1:0] DOUT;

  modport master (
    output ADDR,
    output DIN,
    output WE,
    input  SEL,
    input  DOUT
  );

  modport slave (
    input  ADDR,
    input  DIN,
    input  WE,
    output SEL,
    output DOUT
  );
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller for the 0xFFF0-0xFFFF page: debounced KEY/SW
// inputs with sticky press flags, display registers and an interval timer.
// Reads are combinational for the writeback mux; writes commit on CLK.
module io_ctrl #(
  parameter int DBITS  = 16,
  parameter int DEBCYC = 50000,
  parameter int TDIV   = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  io_ctrl_if.slave         bus,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] HEXOUT,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  localparam int DPW = (DEBCYC > 1) ? $clog2(DEBCYC) : 1;
  localparam int TPW = (TDIV > 1) ? $clog2(TDIV) : 1;

  localparam logic [3:0] A_KDATA = 4'h0;
  localparam logic [3:0] A_SDATA = 4'h2;
  localparam logic [3:0] A_STAT  = 4'h4;
  localparam logic [3:0] A_TCNT  = 4'h6;
  localparam logic [3:0] A_HEX   = 4'h8;
  localparam logic [3:0] A_LEDR  = 4'hA;
  localparam logic [3:0] A_LEDG  = 4'hC;
  localparam logic [3:0] A_TLIM  = 4'hE;

  // input synchronizers (KEY is active-low, so it idles at 1)
  logic [3:0]       r_key_s1, r_key_s2;
  logic [9:0]       r_sw_s1, r_sw_s2;
  // debounce state, kept in "pressed" polarity for keys
  logic [DPW-1:0]   r_dpre;
  logic [3:0]       r_kprev, r_kdeb, r_kdeb_d;
  logic [9:0]       r_swprev, r_swdeb;
  // status, timer and display registers
  logic [9:0]       r_stat;
  logic [TPW-1:0]   r_tpre;
  logic [DBITS-1:0] r_tcnt, r_tlim, r_hex;
  logic [9:0]       r_ledr;
  logic [7:0]       r_ledg;

  logic             w_sel, w_wr, w_dtick;
  logic             w_wr_stat, w_wr_tcnt, w_wr_tlim;
  logic [3:0]       w_kagree, w_press;
  logic [9:0]       w_swagree, w_clr, w_set, w_stat_n;
  logic [TPW-1:0]   w_tpre_n;
  logic [DBITS-1:0] w_tcnt_n, w_tlim_n, w_dout;
  logic             w_wrap_set;

  assign w_sel     = (bus.ADDR[DBITS-1:4] == {(DBITS-4){1'b1}});
  assign w_wr      = bus.WE & w_sel;
  assign w_wr_stat = w_wr & (bus.ADDR[3:0] == A_STAT);
  assign w_wr_tcnt = w_wr & (bus.ADDR[3:0] == A_TCNT);
  assign w_wr_tlim = w_wr & (bus.ADDR[3:0] == A_TLIM);
  assign w_dtick   = (r_dpre == DPW'(DEBCYC - 1));

  // a bit is accepted only when the new sample matches the previous one
  assign w_kagree  = ~((~r_key_s2) ^ r_kprev);
  assign w_swagree = ~(r_sw_s2 ^ r_swprev);
  assign w_press   = r_kdeb & ~r_kdeb_d;

  // shared debounce sample prescaler
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dpre <= '0;
    end else if (w_dtick) begin
      r_dpre <= '0;
    end else begin
      r_dpre <= r_dpre + DPW'(1);
    end
  end

  // two-flop synchronizers, debounce sampling and press edge register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_sw_s1  <= 10'h000;
      r_sw_s2  <= 10'h000;
      r_kprev  <= 4'h0;
      r_kdeb   <= 4'h0;
      r_kdeb_d <= 4'h0;
      r_swprev <= 10'h000;
      r_swdeb  <= 10'h000;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      r_kdeb_d <= r_kdeb;
      if (w_dtick) begin
        r_kprev  <= ~r_key_s2;
        r_swprev <= r_sw_s2;
        r_kdeb   <= (r_kdeb & ~w_kagree) | (r_kprev & w_kagree);
        r_swdeb  <= (r_swdeb & ~w_swagree) | (r_swprev & w_swagree);
      end
    end
  end

  // timer next-state: bus writes beat ticks, TLIM==0 freezes everything
  always_comb begin
    w_tpre_n   = r_tpre;
    w_tcnt_n   = r_tcnt;
    w_tlim_n   = r_tlim;
    w_wrap_set = 1'b0;
    if (w_wr_tcnt || w_wr_tlim) begin
      w_tpre_n = '0;
      if (w_wr_tcnt) begin
        w_tcnt_n = bus.DIN;
      end else begin
        w_tcnt_n = r_tcnt;
      end
      if (w_wr_tlim) begin
        w_tlim_n = bus.DIN;
      end else begin
        w_tlim_n = r_tlim;
      end
    end else if (r_tlim == '0) begin
      w_tpre_n = '0;
    end else if (r_tpre == TPW'(TDIV - 1)) begin
      w_tpre_n = '0;
      if (r_tcnt == (r_tlim - DBITS'(1))) begin
        w_tcnt_n   = '0;
        w_wrap_set = 1'b1;
      end else begin
        // a count above the limit runs to all-ones and rolls over silently
        w_tcnt_n = r_tcnt + DBITS'(1);
      end
    end else begin
      w_tpre_n = r_tpre + TPW'(1);
    end
  end

  // status next-state: W1C clears, but a same-cycle set event wins
  always_comb begin
    w_clr    = 10'h000;
    w_set    = 10'h000;
    w_stat_n = r_stat;
    if (w_wr_stat) begin
      w_clr = bus.DIN[9:0];
    end else begin
      w_clr = 10'h000;
    end
    w_set    = {w_wrap_set & r_stat[8], w_wrap_set, w_press & r_stat[3:0], w_press};
    w_stat_n = (r_stat & ~w_clr) | w_set;
  end

  // timer and status registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tpre <= '0;
      r_tcnt <= '0;
      r_tlim <= '0;
      r_stat <= 10'h000;
    end else begin
      r_tpre <= w_tpre_n;
      r_tcnt <= w_tcnt_n;
      r_tlim <= w_tlim_n;
      r_stat <= w_stat_n;
    end
  end

  // display registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hex  <= '0;
      r_ledr <= 10'h000;
      r_ledg <= 8'h00;
    end else begin
      if (w_wr && (bus.ADDR[3:0] == A_HEX)) begin
        r_hex <= bus.DIN;
      end
      if (w_wr && (bus.ADDR[3:0] == A_LEDR)) begin
        r_ledr <= bus.DIN[9:0];
      end
      if (w_wr && (bus.ADDR[3:0] == A_LEDG)) begin
        r_ledg <= bus.DIN[7:0];
      end
    end
  end

  // combinational read mux; off-page addresses read as zero
  always_comb begin
    w_dout = '0;
    if (w_sel) begin
      case (bus.ADDR[3:0])
        A_KDATA: w_dout = DBITS'(r_kdeb);
        A_SDATA: w_dout = DBITS'(r_swdeb);
        A_STAT:  w_dout = DBITS'(r_stat);
        A_TCNT:  w_dout = r_tcnt;
        A_HEX:   w_dout = r_hex;
        A_LEDR:  w_dout = DBITS'(r_ledr);
        A_LEDG:  w_dout = DBITS'(r_ledg);
        A_TLIM:  w_dout = r_tlim;
        default: w_dout = DBITS'(16'hDEAD);
      endcase
    end else begin
      w_dout = '0;
    end
  end

  assign bus.SEL  = w_sel;
  assign bus.DOUT = w_dout;
  assign HEXOUT   = r_hex;
  assign LEDR     = r_ledr;
  assign LEDG     = r_ledg;

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: register-map vector table, hand-written
// key/timer/reset sequences, and a randomized phase against a register model.
module tb_io_ctrl;
  localparam int DEBCYC = 4;
  localparam int TDIV   = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'h000;
  logic [15:0] HEXOUT;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  io_ctrl_if #(.DBITS(16)) bus ();

  io_ctrl #(.DBITS(16), .DEBCYC(DEBCYC), .TDIV(TDIV)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .KEY(KEY), .SW(SW), .HEXOUT(HEXOUT), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // reference model: architectural register contents only
  logic [15:0] m_hex, m_tcnt, m_tlim;
  logic [9:0]  m_ledr, m_stat, m_sw;
  logic [7:0]  m_ledg;
  int          m_run;   // enabled timer cycles since the last timer write

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_hex = 16'h0; m_tcnt = 16'h0; m_tlim = 16'h0;
    m_ledr = 10'h0; m_stat = 10'h0; m_sw = 10'h0; m_ledg = 8'h0;
    m_run = 0;
  endfunction

  function automatic void model_step(input logic [15:0] a, input logic [15:0] d, input logic w);
    logic       wr;
    logic [9:0] clr;
    logic       wrap, tovr;
    wr = w && (a[15:4] == 12'hFFF);
    clr = 10'h0; wrap = 1'b0; tovr = 1'b0;
    if (wr && a == 16'hFFF4) clr = d[9:0];
    if (wr && (a == 16'hFFF6 || a == 16'hFFFE)) begin
      if (a == 16'hFFF6) m_tcnt = d; else m_tlim = d;
      m_run = 0;
    end else if (m_tlim == 16'h0) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run % TDIV == 0) begin
        if (int'(m_tcnt) + 1 == int'(m_tlim)) begin
          m_tcnt = 16'h0; wrap = 1'b1; tovr = m_stat[8];
        end else begin
          m_tcnt = 16'((int'(m_tcnt) + 1) % 65536);
        end
      end
    end
    m_stat = (m_stat & ~clr) | {tovr, wrap, 8'h00};
    if (wr && a == 16'hFFF8) m_hex = d;
    if (wr && a == 16'hFFFA) m_ledr = d[9:0];
    if (wr && a == 16'hFFFC) m_ledg = d[7:0];
  endfunction

  // keys stay released whenever the model is consulted
  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a)
      16'hFFF0: return 16'h0000;
      16'hFFF2: return {6'h0, m_sw};
      16'hFFF4: return {6'h0, m_stat};
      16'hFFF6: return m_tcnt;
      16'hFFF8: return m_hex;
      16'hFFFA: return {6'h0, m_ledr};
      16'hFFFC: return {8'h0, m_ledg};
      16'hFFFE: return m_tlim;
      default:  return 16'hDEAD;
    endcase
  endfunction

  // one bus cycle: drive on negedge, commit on posedge, sample #1 later
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(negedge CLK);
    bus.ADDR = a; bus.DIN = d; bus.WE = w;
    @(posedge CLK);
    model_step(a, d, w);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic rd_n(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(a, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus.WE = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    model_reset();
    #1;
    RESET = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] din;
    logic        we;
    logic        chk_en;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, d;
    logic        w, seen;

    bus.ADDR = 16'h0; bus.DIN = 16'h0; bus.WE = 1'b0;
    SW = 10'h3FF;
    do_reset();

    // ---------------- register map table ----------------
    vecs[0]  = '{16'hFFF2, 16'h0000, 1'b0, 1'b1, 16'h0000, "sdata_before_ticks"};
    vecs[1]  = '{16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h0000, "kdata_rst"};
    vecs[2]  = '{16'hFFF4, 16'h0000, 1'b0, 1'b1, 16'h0000, "stat_rst"};
    vecs[3]  = '{16'hFFF6, 16'h0000, 1'b0, 1'b1, 16'h0000, "tcnt_rst"};
    vecs[4]  = '{16'hFFF8, 16'h0000, 1'b0, 1'b1, 16'h0000, "hex_rst"};
    vecs[5]  = '{16'hFFF1, 16'h0000, 1'b0, 1'b1, 16'hDEAD, "odd_unmapped"};
    vecs[6]  = '{16'hFFFE, 16'h0000, 1'b0, 1'b1, 16'h0000, "tlim_rst"};
    vecs[7]  = '{16'hFFF8, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, "hex_wr"};
    vecs[8]  = '{16'hFFFA, 16'hFFFF, 1'b1, 1'b1, 16'h03FF, "ledr_wr"};
    vecs[9]  = '{16'hFFFC, 16'h1234, 1'b1, 1'b1, 16'h0034, "ledg_wr"};
    vecs[10] = '{16'hFFF0, 16'h1234, 1'b1, 1'b1, 16'h0000, "kdata_ro"};
    vecs[11] = '{16'h0FF8, 16'h1111, 1'b1, 1'b0, 16'h0000, "offpage_wr"};
    vecs[12] = '{16'hFFF8, 16'h0000, 1'b0, 1'b1, 16'hBEEF, "hex_kept"};
    vecs[13] = '{16'hFFF3, 16'h5555, 1'b1, 1'b1, 16'hDEAD, "unmapped_wr"};
    vecs[14] = '{16'hFFF2, 16'h0000, 1'b0, 1'b1, 16'h03FF, "sdata_debounced"};
    vecs[15] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hDEAD, "unmapped_ff"};
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].addr, vecs[i].din, vecs[i].we);
      if (vecs[i].chk_en) chk(vecs[i].name, bus.DOUT, vecs[i].exp);
    end
    chk("hexout_pin", HEXOUT, 16'hBEEF);
    chk("ledr_pin", {6'h0, LEDR}, 16'h03FF);
    chk("ledg_pin", {8'h0, LEDG}, 16'h0034);

    // ---------------- KEY[2] glitches, then a real press ----------------
    for (int g = 0; g < 3; g++) begin
      KEY[2] = 1'b0; rd_n(16'hFFF4, 1);
      KEY[2] = 1'b1; rd_n(16'hFFF4, 5);
    end
    rd_n(16'hFFF4, 12);
    chk("glitch_no_flag", bus.DOUT, 16'h0000);
    KEY[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      rd_n(16'hFFF4, 1);
      if (bus.DOUT != 16'h0) seen = 1'b1;
    end
    chk("key2_flag", bus.DOUT, 16'h0004);
    rd_n(16'hFFF0, 1);
    chk("key2_kdata", bus.DOUT, 16'h0004);
    rd_n(16'hFFF4, 10);
    KEY = 4'hF;
    rd_n(16'hFFF4, 20);
    chk("key2_once", bus.DOUT, 16'h0004);
    cyc(16'hFFF4, 16'h0004, 1'b1);
    chk("key2_w1c", bus.DOUT, 16'h0000);

    // ---------------- KEY[0] double press and set-beats-clear ----------------
    for (int p = 0; p < 2; p++) begin
      KEY[0] = 1'b0; rd_n(16'hFFF4, 20);
      KEY[0] = 1'b1; rd_n(16'hFFF4, 20);
    end
    chk("key0_overrun", bus.DOUT, 16'h0011);
    KEY[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      rd_n(16'hFFF0, 1);
      if (bus.DOUT[0]) seen = 1'b1;
    end
    chk("key0_deb_seen", {15'h0, seen}, 16'h0001);
    cyc(16'hFFF4, 16'h0001, 1'b1);
    chk("set_beats_w1c", bus.DOUT, 16'h0011);
    KEY[0] = 1'b1; rd_n(16'hFFF4, 20);
    cyc(16'hFFF4, 16'h0001, 1'b1);
    chk("w1c_bit0", bus.DOUT, 16'h0010);
    cyc(16'hFFF4, 16'h0010, 1'b1);
    chk("w1c_ovr0", bus.DOUT, 16'h0000);

    // ---------------- timer TLIM=5 ----------------
    cyc(16'hFFFE, 16'h0005, 1'b1);
    rd_n(16'hFFF6, 12);
    chk("tcnt_at4", bus.DOUT, 16'h0004);
    rd_n(16'hFFF6, 3);
    chk("tcnt_wrap", bus.DOUT, 16'h0000);
    rd_n(16'hFFF4, 1);
    chk("wrap_flag", bus.DOUT, 16'h0100);
    rd_n(16'hFFF4, 14);
    chk("timer_overrun", bus.DOUT, 16'h0300);

    // ---------------- TCNT above TLIM rolls over silently ----------------
    cyc(16'hFFF4, 16'h03FF, 1'b1);
    cyc(16'hFFFE, 16'h0003, 1'b1);
    cyc(16'hFFF6, 16'hFFFE, 1'b1);
    chk("tcnt_wr_visible", bus.DOUT, 16'hFFFE);
    rd_n(16'hFFF6, 3);
    chk("tcnt_ffff", bus.DOUT, 16'hFFFF);
    rd_n(16'hFFF6, 3);
    chk("tcnt_rollover", bus.DOUT, 16'h0000);
    rd_n(16'hFFF4, 1);
    chk("rollover_no_flag", bus.DOUT, 16'h0000);

    // ---------------- reset mid-run with KEY held ----------------
    KEY[1] = 1'b0;
    rd_n(16'hFFF6, 20);
    do_reset();
    chk("rst_hexout", HEXOUT, 16'h0000);
    chk("rst_ledr", {6'h0, LEDR}, 16'h0000);
    chk("rst_ledg", {8'h0, LEDG}, 16'h0000);
    bus.ADDR = 16'hFFF4; #1;
    chk("rst_stat", bus.DOUT, 16'h0000);
    bus.ADDR = 16'hFFF6; #1;
    chk("rst_tcnt", bus.DOUT, 16'h0000);
    bus.ADDR = 16'hFFF0; #1;
    chk("rst_kdata", bus.DOUT, 16'h0000);
    bus.ADDR = 16'hFFFE; #1;
    chk("rst_tlim", bus.DOUT, 16'h0000);
    rd_n(16'hFFF6, 15);
    chk("tlim0_frozen", bus.DOUT, 16'h0000);
    cyc(16'hFFF6, 16'h0007, 1'b1);
    rd_n(16'hFFF6, 10);
    chk("tlim0_hold7", bus.DOUT, 16'h0007);
    KEY = 4'hF;

    // ---------------- randomized phase against the model ----------------
    SW = 10'($urandom_range(0, 1023));
    do_reset();
    rd_n(16'h1234, 14);
    m_sw = SW;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(16'h0000, 16'hFFEF));
      else a = 16'hFFF0 + 16'($urandom_range(0, 15));
      if (a == 16'hFFFE) d = 16'($urandom_range(0, 6));
      else if (a == 16'hFFF6) d = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom_range(0, 8));
      else d = 16'($urandom);
      w = ($urandom_range(0, 2) == 0);
      cyc(a, d, w);
      if (a[15:4] == 12'hFFF) chk("rand_dout", bus.DOUT, model_read(a));
      chk("rand_hexout", HEXOUT, m_hex);
      chk("rand_ledr", {6'h0, LEDR}, {6'h0, m_ledr});
      chk("rand_ledg", {8'h0, LEDG}, {8'h0, m_ledg});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
